uart_receiver: RTL

- UART receive path for the lab2 serial link: the consumer of the baud controller's 16x oversampling tick.
- Recovers frames from the serial line RxD using the `sample_ENABLE` tick.
- Frame format: 1 start bit, 8 data bits LSB first, even parity bit, 1 stop bit.
- Presents the received byte with a one-cycle valid strobe plus sticky per-frame parity and framing error flags.

---
 rtl/uart_receiver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive FSM: oversampled start detection, LSB-first data,
// even parity and stop-bit checks, one-clk valid strobe with held per-frame results.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int MID_SAMPLE = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(MID_SAMPLE);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t               state, state_nxt;
  logic                 rxd_meta, rxd_s;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 perr, perr_nxt;
  logic                 done;
  logic                 at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

  assign at_last = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      perr      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      perr      <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    perr_nxt  = perr;
    done      = 1'b0;
    if (!Rx_EN) begin
      state_nxt = IDLE;
      tick_nxt  = '0;
      bit_nxt   = '0;
    end else if (sample_ENABLE) begin
      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = rxd_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          tick_nxt = at_last ? '0 : tick_cnt + TW'(1);
          if (at_last) begin
            shift_nxt = {rxd_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) state_nxt = PARITY;
            else                     bit_nxt   = bit_cnt + BW'(1);
          end
        end
        PARITY: begin
          tick_nxt = at_last ? '0 : tick_cnt + TW'(1);
          if (at_last) begin
            perr_nxt  = rxd_s ^ (^shift_reg);
            state_nxt = STOP;
          end
        end
        STOP: begin
          tick_nxt = at_last ? '0 : tick_cnt + TW'(1);
          if (at_last) begin
            done      = 1'b1;
            // A low stop bit means the line may still be held low; wait for it to rise.
            state_nxt = rxd_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID <= done;
      if (done) begin
        Rx_DATA   <= shift_reg;
        Rx_PERROR <= perr;
        Rx_FERROR <= ~rxd_s;
      end
    end
  end
endmodule
